// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the restoring divider: word size and FSM state codes.
package sequential_divider_pkg;
    localparam int WORD_SIZE = 32;

    typedef logic [1:0] div_state_t;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;
endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring-division iteration: shift {rem,quo} left and trial-subtract the divisor.
module sequential_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;

    assign shifted   = {rem_i, quo_i[WIDTH-1]};
    assign no_borrow = (shifted >= {1'b0, divisor_i});
    // When no borrow occurs the true difference is below the divisor, so WIDTH bits suffice.
    assign diff      = shifted[WIDTH-1:0] - divisor_i;

    assign rem_o = no_borrow ? diff : shifted[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], no_borrow};
endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider for DIV/DIVU with start/busy/done handshake.
//  state    | meaning
//  DIV_IDLE | waiting for start; results held
//  DIV_CALC | one quotient bit per cycle, WIDTH cycles
//  DIV_FIX  | sign fixup / divide-by-zero result, then done
module sequential_divider
    import sequential_divider_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign a_neg_in = is_signed & dividend[WIDTH-1];
    assign b_neg_in = is_signed & divisor[WIDTH-1];

    sequential_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d = DIV_CALC;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    dvd_d   = dividend;
                    quo_d   = a_neg_in ? -dividend : dividend;
                    dvs_d   = b_neg_in ? -divisor : divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV_FIX: begin
                state_d = DIV_IDLE;
                done_d  = 1'b1;
                // Zero divisor bypasses sign fixup and returns the raw dividend.
                if (dvs_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
                    remainder_d = a_neg_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != DIV_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench: arithmetic reference model checked every cycle, plus directed literal cases.
module tb_sequential_divider;
    localparam int W   = 32;
    localparam int LAT = W + 2;  // negedges from the start-sampling negedge to the done negedge

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_fail = 0;

    sequential_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb, lq, lr;
        if (b == '0) begin
            q = '1; r = a; z = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b; z = 1'b0;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            z  = 1'b0;
        end
    endfunction

    // Reference model: one op in flight, result appears LAT negedges after acceptance.
    int           ncyc = 0;
    bit           inflight = 1'b0;
    int           due = 0;
    logic [W-1:0] pend_q = '0, pend_r = '0, held_q = '0, held_r = '0;
    logic         pend_z = 1'b0, held_z = 1'b0;

    always @(negedge clk) begin
        bit exp_done;
        ncyc++;
        if (!rst_n) begin
            inflight = 1'b0;
            held_q = '0; held_r = '0; held_z = 1'b0;
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            check("rst_q", 64'(quotient), 64'(0));
            check("rst_r", 64'(remainder), 64'(0));
            check("rst_dbz", 64'(div_by_zero), 64'(0));
        end else begin
            exp_done = inflight && (ncyc == due);
            if (exp_done) begin
                held_q = pend_q; held_r = pend_r; held_z = pend_z;
                inflight = 1'b0;
            end
            check("done", 64'(done), 64'(exp_done));
            check("busy", 64'(busy), 64'(inflight));
            check("quotient", 64'(quotient), 64'(held_q));
            check("remainder", 64'(remainder), 64'(held_r));
            check("div_by_zero", 64'(div_by_zero), 64'(held_z));
            if (start && !inflight) begin
                model(dividend, divisor, is_signed, pend_q, pend_r, pend_z);
                inflight = 1'b1;
                due = ncyc + LAT;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit now);
        if (!now) begin
            @(posedge clk); #1;
        end
        dividend = a; divisor = b; is_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!done && k < 100);
        check("wait_done", 64'(done), 64'(1));
    endtask

    task automatic expect_res(input string name, input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        check({name, "_q"}, 64'(quotient), 64'(q));
        check({name, "_r"}, 64'(remainder), 64'(r));
        check({name, "_z"}, 64'(div_by_zero), 64'(z));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 20));
            4: return W'(1);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        bit back;
        logic [W-1:0] mq, mr;
        logic mz;

        model(32'd100, 32'd7, 1'b0, mq, mr, mz);
        check("model_100_7_q", 64'(mq), 64'(14));
        model(-32'sd7, 32'd2, 1'b1, mq, mr, mz);
        check("model_m7_2_r", 64'(mr), 64'(32'hFFFF_FFFF));
        model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, mz);
        check("model_ovf_q", 64'(mq), 64'(32'h8000_0000));

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        issue(32'd100, 32'd7, 1'b0, 1'b0);
        wait_done(k);
        check("lat_100_7", 64'(k), 64'(33));
        expect_res("divu_100_7", 32'd14, 32'd2, 1'b0);

        issue(-32'sd7, 32'd2, 1'b1, 1'b0);
        wait_done(k);
        expect_res("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        issue(32'd7, -32'sd2, 1'b1, 1'b0);
        wait_done(k);
        expect_res("div_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);

        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        wait_done(k);
        expect_res("div_ovf", 32'h8000_0000, 32'd0, 1'b0);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_done(k);
        expect_res("divu_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0);

        issue(32'd1234, 32'd0, 1'b0, 1'b0);
        wait_done(k);
        check("lat_dbz", 64'(k), 64'(33));
        expect_res("dbz", 32'hFFFF_FFFF, 32'd1234, 1'b1);
        issue(32'd9, 32'd3, 1'b0, 1'b0);
        wait_done(k);
        expect_res("after_dbz", 32'd3, 32'd0, 1'b0);

        issue(32'd50, 32'd5, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        dividend = 32'd77; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(k);
        check("lat_ignored_start", 64'(k), 64'(23));
        expect_res("ignored_start", 32'd10, 32'd0, 1'b0);
        issue(32'd600, 32'd7, 1'b0, 1'b1);
        wait_done(k);
        check("lat_back2back", 64'(k), 64'(33));
        expect_res("back2back", 32'd85, 32'd5, 1'b0);

        issue(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_q", 64'(quotient), 64'(0));
        check("midrst_r", 64'(remainder), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        issue(32'd1000, 32'd3, 1'b0, 1'b1);
        wait_done(k);
        expect_res("after_rst", 32'd333, 32'd1, 1'b0);

        back = 1'b0;
        for (int i = 0; i < 150; i++) begin
            issue(pick(), pick(), 1'($urandom_range(0, 1)), back);
            wait_done(k);
            check("lat_rand", 64'(k), 64'(33));
            back = 1'($urandom_range(0, 1));
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
